// File: rtl/alu_sequencer.sv
// alu_sequencer: collects operand A, operand B and an opcode byte from a
// serial receiver, strobes them into an external ALU, waits two cycles for
// the ALU to settle, captures result/carry and hands the result byte to a
// transmitter. Inter-byte gaps inside a frame are bounded by TIMEOUT_CYCLES.
//
// Optional feature macro: ALU_SEQ_CARRY_TX_EN -- when defined, a second
// byte {zeros, carry} is transmitted after the result byte.
//
// Handshakes: i_rx_valid is a one-cycle strobe with no backpressure; a byte
// that arrives while the frame is executing or transmitting is dropped and
// flagged on the sticky o_overrun. o_tx_start is a one-cycle request that is
// only raised while i_tx_busy=0, and o_tx_data is held until the next request.
module alu_sequencer #(
   parameter int BUS_SIZE       = 8,
   parameter int OPCODE_SIZE    = 6,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic [BUS_SIZE-1:0] i_rx_data,
   input  logic                i_rx_valid,
   output logic [BUS_SIZE-1:0] o_alu_bus,
   output logic                o_load_a,
   output logic                o_load_b,
   output logic                o_load_op,
   input  logic [BUS_SIZE-1:0] i_alu_result,
   input  logic                i_alu_carry,
   output logic [BUS_SIZE-1:0] o_tx_data,
   output logic                o_tx_start,
   input  logic                i_tx_busy,
   output logic                o_overrun,
   output logic                o_timeout,
   output logic [2:0]          o_dbg_state,
   output logic                o_dbg_carry
);

   localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_W-1:0]    GAP_TERM = GAP_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BUS_SIZE-1:0] OP_MASK  = BUS_SIZE'((64'd1 << OPCODE_SIZE) - 64'd1);

   typedef enum logic [2:0] {
      GET_A  = 3'd0,
      GET_B  = 3'd1,
      GET_OP = 3'd2,
      EXEC   = 3'd3,
      SEND   = 3'd4
`ifdef ALU_SEQ_CARRY_TX_EN
      ,
      SEND_C = 3'd5
`endif
   } state_t;

   state_t              state_q, state_d;
   logic                exec_cnt_q, exec_cnt_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [BUS_SIZE-1:0] result_q;
   logic                carry_q;
   logic                capture;
   logic                gap_expired;
   logic [BUS_SIZE-1:0] bus_d, tx_data_d;
   logic                load_a_d, load_b_d, load_op_d;
   logic                tx_start_d, timeout_d, overrun_d;

   assign gap_expired = (gap_q == GAP_TERM);
   assign o_dbg_state = state_q;
   assign o_dbg_carry = carry_q;

   // State, EXEC cycle counter and inter-byte gap counter.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= GET_A;
         exec_cnt_q <= 1'b0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         exec_cnt_q <= exec_cnt_d;
         gap_q      <= gap_d;
      end
   end

   // Next-state and next-output decode; timeout takes priority over a byte.
   always_comb begin
      state_d    = state_q;
      exec_cnt_d = 1'b0;
      gap_d      = '0;
      bus_d      = o_alu_bus;
      load_a_d   = 1'b0;
      load_b_d   = 1'b0;
      load_op_d  = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = o_tx_data;
      timeout_d  = 1'b0;
      overrun_d  = o_overrun;
      capture    = 1'b0;
      case (state_q)
         GET_A: begin
            if (i_rx_valid) begin
               bus_d    = i_rx_data;
               load_a_d = 1'b1;
               state_d  = GET_B;
            end
         end
         GET_B, GET_OP: begin
            if (gap_expired) begin
               timeout_d = 1'b1;
               state_d   = GET_A;
            end else if (i_rx_valid) begin
               if (state_q == GET_B) begin
                  bus_d    = i_rx_data;
                  load_b_d = 1'b1;
                  state_d  = GET_OP;
               end else begin
                  bus_d     = i_rx_data & OP_MASK;
                  load_op_d = 1'b1;
                  state_d   = EXEC;
               end
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         EXEC: begin
            overrun_d  = o_overrun | i_rx_valid;
            exec_cnt_d = ~exec_cnt_q;
            if (exec_cnt_q) begin
               capture = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            overrun_d = o_overrun | i_rx_valid;
            if (!i_tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = result_q;
`ifdef ALU_SEQ_CARRY_TX_EN
               state_d    = SEND_C;
`else
               state_d    = GET_A;
`endif
            end
         end
`ifdef ALU_SEQ_CARRY_TX_EN
         SEND_C: begin
            overrun_d = o_overrun | i_rx_valid;
            // Skip the cycle our own request is still high: busy lags it.
            if (!i_tx_busy && !o_tx_start) begin
               tx_start_d = 1'b1;
               tx_data_d  = {{(BUS_SIZE-1){1'b0}}, carry_q};
               state_d    = GET_A;
            end
         end
`endif
         default: state_d = GET_A;
      endcase
   end

   // Registered outputs and captured ALU result/carry.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_alu_bus  <= '0;
         o_load_a   <= 1'b0;
         o_load_b   <= 1'b0;
         o_load_op  <= 1'b0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         o_overrun  <= 1'b0;
         o_timeout  <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
      end else begin
         o_alu_bus  <= bus_d;
         o_load_a   <= load_a_d;
         o_load_b   <= load_b_d;
         o_load_op  <= load_op_d;
         o_tx_data  <= tx_data_d;
         o_tx_start <= tx_start_d;
         o_overrun  <= overrun_d;
         o_timeout  <= timeout_d;
         if (capture) begin
            result_q <= i_alu_result;
            carry_q  <= i_alu_carry;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: frames, carry, busy stall, timeout,
// timeout/byte collision, overrun and mid-frame reset.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] alu_bus;
   logic       load_a, load_b, load_op;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       overrun, timeout;
   logic [2:0] dbg_state;
   logic       dbg_carry;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   alu_sequencer #(.BUS_SIZE(8), .OPCODE_SIZE(6), .TIMEOUT_CYCLES(16)) dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_alu_bus(alu_bus), .o_load_a(load_a), .o_load_b(load_b), .o_load_op(load_op),
      .i_alu_result(alu_result), .i_alu_carry(alu_carry),
      .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
      .o_overrun(overrun), .o_timeout(timeout),
      .o_dbg_state(dbg_state), .o_dbg_carry(dbg_carry)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Waits for o_tx_start, compares the byte with the scoreboard head and
   // confirms the request lasts one cycle.
   task automatic wait_tx(input string tag, output int cyc);
      logic [7:0] exp;
      int got;
      cyc = 0;
      got = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            cyc = i;
            got = 1;
            break;
         end
      end
      check({tag, "_start_seen"}, got, 1);
      if (got == 1) begin
         if (exp_q.size() == 0) begin
            check({tag, "_unexpected_tx"}, 1, 0);
         end else begin
            exp = exp_q.pop_front();
            check({tag, "_tx_data"}, tx_data, exp);
         end
         @(negedge clk);
         check({tag, "_start_pulse"}, tx_start, 1'b0);
      end
   endtask

   task automatic finish_frame(input string tag);
      int cyc;
      int n;
`ifdef ALU_SEQ_CARRY_TX_EN
      wait_tx({tag, "_carry"}, cyc);
`endif
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (tx_start === 1'b1) n++;
      end
      check({tag, "_no_extra_tx"}, n, 0);
      check({tag, "_back_to_get_a"}, dbg_state, 3'd0);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] op_bus,
                            input logic [7:0] res, input logic cy);
      int cyc;
      alu_result = res;
      alu_carry  = cy;
      send_byte(a);
      check({tag, "_strobe_a"}, {load_a, load_b, load_op}, 3'b100);
      check({tag, "_bus_a"}, alu_bus, a);
      send_byte(b);
      check({tag, "_strobe_b"}, {load_a, load_b, load_op}, 3'b010);
      check({tag, "_bus_b"}, alu_bus, b);
      send_byte(op);
      check({tag, "_strobe_op"}, {load_a, load_b, load_op}, 3'b001);
      check({tag, "_bus_op"}, alu_bus, op_bus);
      check({tag, "_state_exec"}, dbg_state, 3'd3);
      exp_q.push_back(res);
`ifdef ALU_SEQ_CARRY_TX_EN
      exp_q.push_back({7'd0, cy});
`endif
      wait_tx(tag, cyc);
      check({tag, "_latency"}, cyc, 3);
      check({tag, "_carry_captured"}, dbg_carry, cy);
      check({tag, "_bus_hold"}, alu_bus, op_bus);
      finish_frame(tag);
   endtask

   initial begin
      int cyc;
      int n;
      logic [7:0] last_tx;
      rst_n      = 1'b0;
      rx_data    = 8'h00;
      rx_valid   = 1'b0;
      alu_result = 8'h00;
      alu_carry  = 1'b0;
      tx_busy    = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_outputs", {alu_bus, load_a, load_b, load_op, tx_data, tx_start, overrun, timeout}, 0);
      check("rst_state", dbg_state, 3'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic frame and carry frame
      run_frame("f1", 8'h05, 8'h03, 8'h20, 8'h20, 8'h08, 1'b0);
      run_frame("f2", 8'hFF, 8'h01, 8'h20, 8'h20, 8'h00, 1'b1);
`ifdef ALU_SEQ_CARRY_TX_EN
      last_tx = 8'h01;
`else
      last_tx = 8'h00;
`endif

      // transmitter busy for 50+ cycles; opcode upper bits masked
      alu_result = 8'h3C;
      alu_carry  = 1'b0;
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'hE1);
      check("busy_bus_op_masked", alu_bus, 8'h21);
      tx_busy = 1'b1;
      n = 0;
      for (int i = 0; i < 52; i++) begin
         @(negedge clk);
         if (tx_start !== 1'b0 || tx_data !== last_tx) n++;
      end
      check("busy_no_start_data_stable", n, 0);
      check("busy_state_send", dbg_state, 3'd4);
      tx_busy = 1'b0;
      exp_q.push_back(8'h3C);
`ifdef ALU_SEQ_CARRY_TX_EN
      exp_q.push_back(8'h00);
`endif
      wait_tx("busy", cyc);
      check("busy_latency", cyc, 1);
      finish_frame("busy");

      // inter-byte timeout
      send_byte(8'h05);
      n = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (timeout !== 1'b0) n++;
      end
      check("tmo_no_early_pulse", n, 0);
      @(negedge clk);
      check("tmo_pulse", timeout, 1'b1);
      check("tmo_state_get_a", dbg_state, 3'd0);
      @(negedge clk);
      check("tmo_pulse_once", timeout, 1'b0);

      // byte arrives in the same cycle as timeout expiry
      send_byte(8'h05);
      repeat (15) @(negedge clk);
      rx_data  = 8'h66;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("coll_timeout", timeout, 1'b1);
      check("coll_no_load_b", load_b, 1'b0);
      check("coll_no_overrun", overrun, 1'b0);
      check("coll_bus_hold", alu_bus, 8'h05);
      check("coll_state", dbg_state, 3'd0);

      // fresh frame after timeout
      run_frame("fresh", 8'h07, 8'h02, 8'h22, 8'h22, 8'h09, 1'b0);

      // byte during EXEC
      alu_result = 8'h33;
      alu_carry  = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h20);
      rx_data  = 8'h99;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      check("ovr_set", overrun, 1'b1);
      check("ovr_no_strobe", {load_a, load_b, load_op}, 3'b000);
      check("ovr_bus_hold", alu_bus, 8'h20);
      exp_q.push_back(8'h33);
`ifdef ALU_SEQ_CARRY_TX_EN
      exp_q.push_back(8'h00);
`endif
      wait_tx("ovr", cyc);
      check("ovr_latency", cyc, 2);
      finish_frame("ovr");
      check("ovr_sticky", overrun, 1'b1);

      // reset after second byte of a frame
      send_byte(8'h41);
      send_byte(8'h42);
      check("mid_pre_load_b", load_b, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", {alu_bus, load_a, load_b, load_op, tx_data, tx_start, overrun, timeout}, 0);
      check("mid_rst_state_carry", {dbg_state, dbg_carry}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame("post", 8'h0A, 8'h0B, 8'h24, 8'h24, 8'h15, 1'b0);
      check("post_overrun_clear", overrun, 1'b0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
